// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Fetch-stage dynamic branch predictor: a 2-bit saturating-counter pattern
// table paired with a direct-mapped branch target buffer, both indexed by
// pc[IDX+1:2]. Lookup is combinational on the IF PC. Training happens on the
// rising clock edge from the EX stage's resolved branch outcome. A
// misprediction produces a registered one-cycle redirect to the PC/IF logic.
//
// Ports
//   clk, rst_n      : clock (rising edge) and asynchronous active-low reset
//   if_pc           : IF-stage fetch PC
//   pred_taken      : predicted direction for if_pc
//   pred_target     : predicted next PC for if_pc
//   ex_valid        : EX stage holds a valid instruction
//   ex_isBranch     : EX instruction is a conditional branch
//   ex_pc           : PC of the EX instruction
//   ex_pred_taken   : prediction carried down with the EX instruction
//   ex_pred_target  : predicted target carried down with the EX instruction
//   ex_bSel         : resolved direction from branchCtrl (1 = taken)
//   ex_target       : resolved branch target
//   redirect        : one-cycle pulse, PC loads redirect_pc and IF/ID flush
//   redirect_pc     : correct next PC after a misprediction
//   mispredict_cnt  : saturating count of mispredicted branches
// -----------------------------------------------------------------------------
module branch_predictor #(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 64
) (
   input  logic            clk,
   input  logic            rst_n,

   input  logic [XLEN-1:0] if_pc,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,

   input  logic            ex_valid,
   input  logic            ex_isBranch,
   input  logic [XLEN-1:0] ex_pc,
   input  logic            ex_pred_taken,
   input  logic [XLEN-1:0] ex_pred_target,
   input  logic            ex_bSel,
   input  logic [XLEN-1:0] ex_target,

   output logic            redirect,
   output logic [XLEN-1:0] redirect_pc,
   output logic [31:0]     mispredict_cnt
);

   localparam int IDX = $clog2(ENTRIES);
   localparam int TW  = XLEN - IDX - 2;

   localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
   localparam logic [1:0]      CNT_WNT  = 2'b01;   // weakly not-taken
   localparam logic [1:0]      CNT_WT   = 2'b10;   // weakly taken
   localparam logic [1:0]      CNT_MAX  = 2'b11;
   localparam logic [1:0]      CNT_MIN  = 2'b00;
   localparam logic [31:0]     MIS_SAT  = 32'hFFFF_FFFF;

   // ---------------------------------------------------------------------------
   // Prediction state
   // ---------------------------------------------------------------------------
   logic [1:0]      cnt_q    [ENTRIES];
   logic [ENTRIES-1:0] valid_q;
   logic [TW-1:0]   tag_q    [ENTRIES];
   logic [XLEN-1:0] target_q [ENTRIES];

   // ---------------------------------------------------------------------------
   // Lookup (IF stage), reads the pre-update table contents
   // ---------------------------------------------------------------------------
   logic [IDX-1:0] l_idx;
   logic [TW-1:0]  l_tag;
   logic           l_hit;

   assign l_idx = if_pc[IDX+1:2];
   assign l_tag = if_pc[XLEN-1:IDX+2];
   assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);

   assign pred_taken  = l_hit && cnt_q[l_idx][1];
   assign pred_target = pred_taken ? target_q[l_idx] : if_pc + PC_STEP;

   // ---------------------------------------------------------------------------
   // Update (EX stage)
   // ---------------------------------------------------------------------------
   logic           upd;
   logic [IDX-1:0] u_idx;
   logic [TW-1:0]  u_tag;
   logic           u_hit;
   logic [1:0]     u_cnt;
   logic [1:0]     u_cnt_d;
   logic           mis;

   assign upd   = ex_valid && ex_isBranch;
   assign u_idx = ex_pc[IDX+1:2];
   assign u_tag = ex_pc[XLEN-1:IDX+2];
   assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
   assign u_cnt = cnt_q[u_idx];

   // Wrong direction, or right direction (taken) but wrong target.
   assign mis = upd && ((ex_pred_taken != ex_bSel) ||
                        (ex_bSel && (ex_pred_target != ex_target)));

   // A taken branch that does not own the entry (empty or another tag)
   // takes it over and starts weakly taken; otherwise saturating step.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      u_cnt_d = u_cnt;
      if (ex_bSel) begin
         if (!u_hit)                u_cnt_d = CNT_WT;
         else if (u_cnt != CNT_MAX) u_cnt_d = u_cnt + 2'b01;
      end else if (u_cnt != CNT_MIN) begin
         u_cnt_d = u_cnt - 2'b01;
      end
   end

   // Direction counters and valid bits must come out of reset in a known
   // state, so they live in the reset domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            cnt_q[i] <= CNT_WNT;
         end
         valid_q <= '0;
      end else if (upd) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values, independent of block ordering.
         cnt_q[u_idx] <= u_cnt_d;
         if (ex_bSel) valid_q[u_idx] <= 1'b1;
      end
   end

   // NOTE: tag and target are plain storage with no reset; they are only
   // ever consulted behind valid_q, and leaving them unreset lets the table
   // map onto RAM.
   always_ff @(posedge clk) begin
      if (upd && ex_bSel) begin
         tag_q[u_idx]    <= u_tag;
         target_q[u_idx] <= ex_target;
      end
   end

   // ---------------------------------------------------------------------------
   // Redirect and misprediction statistics
   // ---------------------------------------------------------------------------
   logic            redirect_q;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
   logic [31:0]     mis_cnt_q, mis_cnt_d;

   always_comb begin
      redirect_pc_d = redirect_pc_q;
      mis_cnt_d     = mis_cnt_q;
      if (mis) begin
         redirect_pc_d = ex_bSel ? ex_target : ex_pc + PC_STEP;
         if (mis_cnt_q != MIS_SAT) mis_cnt_d = mis_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         mis_cnt_q     <= '0;
      end else begin
         redirect_q    <= mis;
         redirect_pc_q <= redirect_pc_d;
         mis_cnt_q     <= mis_cnt_d;
      end
   end

   assign redirect       = redirect_q;
   assign redirect_pc    = redirect_pc_q;
   assign mispredict_cnt = mis_cnt_q;

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor for the fetch stage. It pairs a 2-bit saturating-counter pattern table with a direct-mapped branch target buffer (BTB).
- Lookup is combinational on the IF-stage PC. Update comes from the EX stage using the resolved branch decision produced by branchCtrl (bSel).
- On a misprediction it issues a registered, one-cycle redirect and flush to the PC/IF logic.

Parameters:
- XLEN, 32, data/address width.
- ENTRIES, 64, number of table entries (power of 2, 4..1024); IDX = log2(ENTRIES).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- if_pc  input  XLEN  IF-stage fetch PC.
- pred_taken  output  1  prediction for if_pc.
- pred_target  output  XLEN  predicted next PC for if_pc.
- ex_valid  input  1  EX stage holds a valid instruction this cycle.
- ex_isBranch  input  1  EX instruction is a conditional branch.
- ex_pc  input  XLEN  PC of the EX instruction.
- ex_pred_taken  input  1  pred_taken carried down the pipeline with the instruction.
- ex_pred_target  input  XLEN  pred_target carried down the pipeline.
- ex_bSel  input  1  resolved outcome from branchCtrl (1 = taken).
- ex_target  input  XLEN  resolved branch target (pc + B-immediate).
- redirect  output  1  one-cycle pulse: PC must load redirect_pc; IF/ID must flush.
- redirect_pc  output  XLEN  correct next PC.
- mispredict_cnt  output  32  count of mispredicted branches.

Behaviour:
- Index: idx = pc[IDX+1:2]. Tag: pc[XLEN-1:IDX+2].
- Per entry state: cnt[1:0], valid, tag, target.
- Reset (async, rst_n=0):
  - all cnt = 2'b01 (weakly not-taken), all valid = 0.
  - redirect = 0, redirect_pc = 0, mispredict_cnt = 0.
  - tag and target need not reset.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag[idx] == if_pc tag.
  - pred_taken = hit && cnt[idx][1].
  - pred_target = pred_taken ? target[idx] : if_pc + 4.
  - if_pc addition wraps modulo 2^XLEN.
- Update (rising clk when ex_valid && ex_isBranch; u = ex_pc index):
  - ex_bSel = 1: cnt[u] = min(cnt[u]+1, 3); valid[u] = 1; tag[u] = ex_pc tag; target[u] = ex_target.
  - ex_bSel = 0: cnt[u] = max(cnt[u]-1, 0); BTB fields unchanged.
  - Tag-mismatch replacement on a taken branch: entry overwritten and cnt[u] forced to 2'b10 (weakly taken).
- Mispredict (combinational, internal):
  - mis = ex_valid && ex_isBranch && ((ex_pred_taken != ex_bSel) || (ex_bSel && ex_pred_target != ex_target)).
  - Non-branch instructions never mispredict and never update.
- Redirect (registered, latency 1):
  - next cycle: redirect = mis; when mis, redirect_pc = ex_bSel ? ex_target : ex_pc + 4; otherwise redirect_pc holds its value.
  - redirect is high exactly one cycle per mispredict. Back-to-back mispredicts give consecutive pulses, each with its own redirect_pc.
- mispredict_cnt increments on mis and saturates at 32'hFFFFFFFF (no wrap).
- Same-cycle lookup and update to the same idx: lookup returns the pre-update (old) entry. The new value is visible from the next cycle.
- Reset asserted mid-operation clears state immediately. An in-flight redirect is dropped; no pulse is emitted after reset deassertion.
- Misaligned ex_pc bits [1:0] are ignored.
- Predictions are hints only. Correctness relies on redirect; the block never stalls.

Test Plan:
1. Reset, then if_pc = 32'h00000100 -> pred_taken = 0, pred_target = 32'h00000104, redirect = 0, mispredict_cnt = 0.
2. EX branch ex_pc = 32'h100, ex_pred_taken = 0, ex_bSel = 1, ex_target = 32'h80 -> next cycle redirect = 1 for one cycle, redirect_pc = 32'h80, mispredict_cnt = 1. Then if_pc = 32'h100 -> pred_taken = 1, pred_target = 32'h80.
3. Four consecutive correctly predicted taken updates to 32'h100 saturate cnt at 3. Two not-taken updates (bSel = 0) follow: the first mispredicts with redirect_pc = 32'h104; after the second, pred_taken = 0 (cnt = 1), and mispredict_cnt increments on both.
4. Aliasing: taken branch at 32'h100, then taken branch at 32'h200 (same idx when ENTRIES = 64) with ex_target = 32'h300 -> lookup 32'h100 misses (pred_taken = 0); lookup 32'h200 gives pred_taken = 1, target 32'h300.
5. Same-cycle lookup and update at 32'h100, with the entry at cnt = 1 and taken resolved -> pred_taken = 0 that cycle, 1 the next cycle.
6. ex_pred_taken = 1, ex_bSel = 1, ex_pred_target = 32'h80, ex_target = 32'h90 -> redirect pulse with redirect_pc = 32'h90. Assert rst_n = 0 in the same cycle the pulse is due -> redirect = 0 and mispredict_cnt = 0 immediately, with no pulse after release.
